// File: rtl/psec5_ch_readout_master.sv
// PSEC5 channel readout master: snapshot strobe, 56-bit serial shift-out and result latch.
// Optional frame padding check enabled by defining PSEC5_RDO_FRAME_CHECK_EN (adds FRAME_ERR).
module psec5_ch_readout_master #(
    parameter int unsigned SCLK_DIV       = 4,
    parameter int unsigned INST_PULSE_LEN = 2,
    parameter int unsigned SETTLE_CYCLES  = 8
) (
    input  logic       FCLK,
    input  logic       RSTB,
    input  logic       START,
    input  logic       ABORT,
    output logic       BUSY,
    output logic       DONE,
    output logic       INST_READOUT,
    output logic       SPI_CLK,
    output logic [2:0] SELECT_REG,
    input  logic       CNT_SER,
    output logic [9:0] CA,
    output logic [9:0] CB,
    output logic [9:0] CC,
    output logic [9:0] CD,
    output logic [9:0] CE,
    output logic [2:0] TRIG_CNT
`ifdef PSEC5_RDO_FRAME_CHECK_EN
    ,
    output logic       FRAME_ERR
`endif
);

    localparam int unsigned CNT_W    = 16;
    localparam int unsigned BIT_W    = 6;
    localparam int unsigned LAST_BIT = 55;
`ifdef PSEC5_RDO_FRAME_CHECK_EN
    localparam int unsigned SHREG_W  = 56;
`else
    // Padding bits fall off the top of the register when they are never checked.
    localparam int unsigned SHREG_W  = 53;
`endif

    localparam logic [CNT_W-1:0] ARM_LAST    = CNT_W'(INST_PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST   = CNT_W'(SCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(LAST_BIT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_SETTLE,
        ST_SHIFT_HI,
        ST_SHIFT_LO,
        ST_LATCH
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bitidx_q, bitidx_d, bitidx_inc;
    logic [2:0]           sel_d;
    logic                 abort_pend_q, abort_pend_d;
    logic [SHREG_W-1:0]   shreg_q, shreg_d;
    logic                 ser_meta_q, ser_sync_q;
    logic                 busy_d, done_d, inst_d, sclk_d;
    logic [9:0]           ca_d, cb_d, cc_d, cd_d, ce_d;
    logic [2:0]           trig_d;
`ifdef PSEC5_RDO_FRAME_CHECK_EN
    logic                 ferr_d;
`endif

    assign bitidx_inc = bitidx_q + BIT_W'(1);

    // Next-state, datapath and registered-output values
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bitidx_d     = bitidx_q;
        sel_d        = SELECT_REG;
        abort_pend_d = abort_pend_q;
        shreg_d      = shreg_q;
        ca_d         = CA;
        cb_d         = CB;
        cc_d         = CC;
        cd_d         = CD;
        ce_d         = CE;
        trig_d       = TRIG_CNT;
        done_d       = 1'b0;
`ifdef PSEC5_RDO_FRAME_CHECK_EN
        ferr_d       = FRAME_ERR;
`endif

        case (state_q)
            ST_IDLE: begin
                if (START && !ABORT) begin
                    state_d      = ST_ARM;
                    cnt_d        = '0;
                    bitidx_d     = '0;
                    abort_pend_d = 1'b0;
                end
            end
            ST_ARM: begin
                if (ABORT) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == ARM_LAST) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (ABORT) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_SHIFT_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SHIFT_HI: begin
                abort_pend_d = abort_pend_q | ABORT;
                if (cnt_q == HALF_LAST) begin
                    state_d = ST_SHIFT_LO;
                    cnt_d   = '0;
                    // Byte select moves a full low phase ahead of the next rise
                    if ((bitidx_q[2:0] == 3'd7) && (bitidx_q != BIT_LAST)) begin
                        sel_d = bitidx_inc[5:3];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SHIFT_LO: begin
                abort_pend_d = abort_pend_q | ABORT;
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {shreg_q[SHREG_W-2:0], ser_sync_q};
                    if (bitidx_q == BIT_LAST) begin
                        state_d = ST_LATCH;
                    end else if ((bitidx_q[2:0] == 3'd7) && (abort_pend_q || ABORT)) begin
                        // Abort only on a group boundary so the channel's bit counter stays aligned
                        state_d = ST_IDLE;
                    end else begin
                        bitidx_d = bitidx_inc;
                        state_d  = ST_SHIFT_HI;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LATCH: begin
                ca_d    = shreg_q[9:0];
                cb_d    = shreg_q[19:10];
                cc_d    = shreg_q[29:20];
                cd_d    = shreg_q[39:30];
                ce_d    = shreg_q[49:40];
                trig_d  = shreg_q[52:50];
                done_d  = 1'b1;
`ifdef PSEC5_RDO_FRAME_CHECK_EN
                ferr_d  = |shreg_q[55:53];
`endif
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_IDLE) begin
            sel_d = '0;
        end
        busy_d = (state_d != ST_IDLE);
        inst_d = (state_d == ST_ARM);
        sclk_d = (state_d == ST_SHIFT_HI);
    end

    // State, datapath and output registers
    always_ff @(posedge FCLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bitidx_q     <= '0;
            abort_pend_q <= 1'b0;
            shreg_q      <= '0;
            ser_meta_q   <= 1'b0;
            ser_sync_q   <= 1'b0;
            BUSY         <= 1'b0;
            DONE         <= 1'b0;
            INST_READOUT <= 1'b0;
            SPI_CLK      <= 1'b0;
            SELECT_REG   <= '0;
            CA           <= '0;
            CB           <= '0;
            CC           <= '0;
            CD           <= '0;
            CE           <= '0;
            TRIG_CNT     <= '0;
`ifdef PSEC5_RDO_FRAME_CHECK_EN
            FRAME_ERR    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bitidx_q     <= bitidx_d;
            abort_pend_q <= abort_pend_d;
            shreg_q      <= shreg_d;
            ser_meta_q   <= CNT_SER;
            ser_sync_q   <= ser_meta_q;
            BUSY         <= busy_d;
            DONE         <= done_d;
            INST_READOUT <= inst_d;
            SPI_CLK      <= sclk_d;
            SELECT_REG   <= sel_d;
            CA           <= ca_d;
            CB           <= cb_d;
            CC           <= cc_d;
            CD           <= cd_d;
            CE           <= ce_d;
            TRIG_CNT     <= trig_d;
`ifdef PSEC5_RDO_FRAME_CHECK_EN
            FRAME_ERR    <= ferr_d;
`endif
        end
    end

endmodule

// File: tb/tb_psec5_ch_readout_master.sv
// Scoreboard bench for psec5_ch_readout_master with a behavioural PSEC5 channel model.
// Covers FRAME_ERR when PSEC5_RDO_FRAME_CHECK_EN is defined.
module tb_psec5_ch_readout_master;

    localparam int unsigned SCLK_DIV       = 4;
    localparam int unsigned INST_PULSE_LEN = 2;
    localparam int unsigned SETTLE_CYCLES  = 8;
    localparam int unsigned LATENCY        = 1 + INST_PULSE_LEN + SETTLE_CYCLES + 112 * SCLK_DIV;

    logic       FCLK = 1'b0;
    logic       RSTB = 1'b0;
    logic       START = 1'b0;
    logic       ABORT = 1'b0;
    logic       BUSY, DONE, INST_READOUT, SPI_CLK;
    logic [2:0] SELECT_REG;
    logic       CNT_SER = 1'b0;
    logic [9:0] CA, CB, CC, CD, CE;
    logic [2:0] TRIG_CNT;
`ifdef PSEC5_RDO_FRAME_CHECK_EN
    logic       FRAME_ERR;
`endif

    psec5_ch_readout_master #(
        .SCLK_DIV      (SCLK_DIV),
        .INST_PULSE_LEN(INST_PULSE_LEN),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) dut (
        .FCLK        (FCLK),
        .RSTB        (RSTB),
        .START       (START),
        .ABORT       (ABORT),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .INST_READOUT(INST_READOUT),
        .SPI_CLK     (SPI_CLK),
        .SELECT_REG  (SELECT_REG),
        .CNT_SER     (CNT_SER),
        .CA          (CA),
        .CB          (CB),
        .CC          (CC),
        .CD          (CD),
        .CE          (CE),
        .TRIG_CNT    (TRIG_CNT)
`ifdef PSEC5_RDO_FRAME_CHECK_EN
        ,
        .FRAME_ERR   (FRAME_ERR)
`endif
    );

    always #5 FCLK = ~FCLK;

    longint cyc = 0;
    always @(posedge FCLK) cyc <= cyc + 1;

    // Channel model: snapshot on strobe, one bit per SPI_CLK rise, position wraps mod 8
    logic [55:0] live_w = '0;
    logic [55:0] snap_w = '0;
    logic [2:0]  ch_pos = 3'd0;
    always @(posedge INST_READOUT) snap_w <= live_w;
    always @(posedge SPI_CLK or negedge RSTB) begin
        if (!RSTB) begin
            ch_pos  <= 3'd0;
            CNT_SER <= 1'b0;
        end else begin
            CNT_SER <= snap_w[55 - 8 * int'(SELECT_REG) - int'(ch_pos)];
            ch_pos  <= ch_pos + 3'd1;
        end
    end

    typedef struct {
        logic [55:0] w;
        longint      due;
    } exp_t;
    exp_t sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int rise_cnt = 0;
    int inst_cyc = 0;
    int rise_base = 0;
    logic spi_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [52:0] res();
        return {TRIG_CNT, CE, CD, CC, CB, CA};
    endfunction

    // Monitor: counts strobe cycles and rises, checks byte select and every DONE against the scoreboard
    always @(negedge FCLK) begin
        exp_t e;
        if (RSTB) begin
            if (INST_READOUT) inst_cyc++;
            if (SPI_CLK && !spi_prev) begin
                check("select_reg", 64'(SELECT_REG), 64'((rise_cnt - rise_base) / 8));
                rise_cnt++;
            end
            if (DONE) begin
                done_cnt++;
                if (sb_q.size() == 0) begin
                    check("spurious_done", 64'(DONE), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("result", 64'(res()), 64'(e.w[52:0]));
                    check("done_latency", 64'(cyc), 64'(e.due));
`ifdef PSEC5_RDO_FRAME_CHECK_EN
                    check("frame_err", 64'(FRAME_ERR), 64'(|e.w[55:53]));
`endif
                end
            end
        end
        spi_prev = SPI_CLK;
    end

    task automatic tick();
        @(negedge FCLK);
        #1;
    endtask

    task automatic start_readout(input logic [55:0] w, input bit expect_done);
        live_w    = w;
        rise_base = rise_cnt;
        START     = 1'b1;
        if (expect_done) sb_q.push_back('{w: w, due: cyc + 1 + longint'(LATENCY)});
        tick();
        START = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string name);
        for (int i = 0; i < 1000 && done_cnt == d0; i++) tick();
        check(name, 64'(done_cnt - d0), 64'd1);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 1000 && BUSY; i++) tick();
        check(name, 64'(BUSY), 64'd0);
    endtask

    task automatic wait_rises(input int n, input string name);
        for (int i = 0; i < 1000 && (rise_cnt - rise_base) < n; i++) tick();
        check(name, 64'(rise_cnt - rise_base), 64'(n));
    endtask

    task automatic check_zero_outputs(input string name);
        check(name, 64'({BUSY, DONE, INST_READOUT, SPI_CLK, SELECT_REG, res()}), 64'd0);
`ifdef PSEC5_RDO_FRAME_CHECK_EN
        check({name, "_ferr"}, 64'(FRAME_ERR), 64'd0);
`endif
    endtask

    function automatic logic [55:0] rand_w(input bit clean);
        logic [55:0] w;
        w = 56'({$urandom, $urandom});
        if (clean) w[55:53] = 3'b000;
        return w;
    endfunction

    // Full readout expected to complete; returns the word that should now be held
    task automatic full_readout(input logic [55:0] w, input string name, output logic [52:0] held);
        int d0;
        d0 = done_cnt;
        start_readout(w, 1'b1);
        wait_done(d0, name);
        repeat (4) tick();
        check({name, "_rises"}, 64'(rise_cnt - rise_base), 64'd56);
        check({name, "_busy"}, 64'(BUSY), 64'd0);
        held = w[52:0];
    endtask

    initial begin
        logic [55:0] w;
        logic [52:0] last_res;
        int d0, i0;

        repeat (3) tick();
        check_zero_outputs("reset_state");
        RSTB = 1'b1;
        tick();

        // Fixed pattern frame with strobe length, rise count and exact values
        w  = {3'b000, 3'b100, 10'h001, 10'h2AA, 10'h155, 10'h000, 10'h3FF};
        i0 = inst_cyc;
        full_readout(w, "t1", last_res);
        check("t1_inst_len", 64'(inst_cyc - i0), 64'(INST_PULSE_LEN));
        check("t1_ca", 64'(CA), 64'h3FF);
        check("t1_cd", 64'(CD), 64'h2AA);
        check("t1_trig", 64'(TRIG_CNT), 64'h4);

        // START while busy is ignored
        w  = rand_w(1'b1);
        d0 = done_cnt;
        start_readout(w, 1'b1);
        repeat (98) tick();
        START = 1'b1;
        tick();
        START = 1'b0;
        wait_done(d0, "t2_done");
        repeat (40) tick();
        check("t2_one_done", 64'(done_cnt - d0), 64'd1);
        check("t2_rises", 64'(rise_cnt - rise_base), 64'd56);
        last_res = w[52:0];

        // ABORT after the 19th rise finishes the byte group
        d0 = done_cnt;
        start_readout(rand_w(1'b1), 1'b0);
        wait_rises(19, "t3_reach19");
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        wait_idle("t3_idle");
        repeat (10) tick();
        check("t3_rises", 64'(rise_cnt - rise_base), 64'd24);
        check("t3_no_done", 64'(done_cnt - d0), 64'd0);
        check("t3_hold", 64'(res()), 64'(last_res));
        full_readout(rand_w(1'b1), "t3_after", last_res);

        // ABORT during SETTLE
        d0 = done_cnt;
        start_readout(rand_w(1'b1), 1'b0);
        repeat (3) tick();
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        check("t4_busy", 64'(BUSY), 64'd0);
        check("t4_inst", 64'(INST_READOUT), 64'd0);
        repeat (30) tick();
        check("t4_rises", 64'(rise_cnt - rise_base), 64'd0);
        check("t4_no_done", 64'(done_cnt - d0), 64'd0);
        check("t4_hold", 64'(res()), 64'(last_res));

        // START together with ABORT in idle is ignored
        START = 1'b1;
        ABORT = 1'b1;
        tick();
        START = 1'b0;
        ABORT = 1'b0;
        check("start_abort_idle", 64'(BUSY), 64'd0);

        // Reset mid-shift clears outputs asynchronously; alignment survives
        start_readout(rand_w(1'b1), 1'b0);
        wait_rises(30, "t5_reach30");
        RSTB = 1'b0;
        #1;
        check_zero_outputs("t5_async_reset");
        sb_q.delete();
        repeat (3) tick();
        RSTB = 1'b1;
        tick();
        full_readout(rand_w(1'b1), "t5_after", last_res);

        // Dirty padding then clean frame
        w = rand_w(1'b1);
        w[54] = 1'b1;
        full_readout(w, "t6_dirty", last_res);
        full_readout(rand_w(1'b1), "t6_clean", last_res);

        // Random frames with random padding and occasional stray START
        for (int k = 0; k < 4; k++) begin
            w  = rand_w($urandom_range(0, 1) == 1);
            d0 = done_cnt;
            start_readout(w, 1'b1);
            repeat ($urandom_range(5, 400)) tick();
            START = 1'b1;
            tick();
            START = 1'b0;
            wait_done(d0, "rand_done");
            repeat (4) tick();
            check("rand_rises", 64'(rise_cnt - rise_base), 64'd56);
        end

        repeat (20) tick();
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/psec5_ch_readout_master.md
Name: psec5_ch_readout_master

Overview:
- FCLK-domain readout master for one PSEC5 channel digital block.
- On START it pulses INST_READOUT so the channel latches its 56-bit counter/trigger snapshot.
- It then drives SPI_CLK and SELECT_REG to shift out all 7 bytes over CNT_SER and deserializes them into CA..CE and TRIG_CNT.
- It sits between the chip-level readout sequencer and each channel.

Parameters:
SCLK_DIV, 4, SPI_CLK half-period in FCLK cycles; legal range 3..255.
INST_PULSE_LEN, 2, INST_READOUT high time in FCLK cycles; must be at least 1.
SETTLE_CYCLES, 8, idle FCLK cycles between INST_READOUT falling and the first SPI_CLK rise; must be at least 1.

Ports:
FCLK  in  1  clock
RSTB  in  1  reset; asynchronous, active-low. Shared with the channel block so its serial bit position is aligned.
START  in  1  request a readout; single-cycle sampled.
ABORT  in  1  terminate the readout at the next byte boundary.
BUSY  out  1  readout in progress.
DONE  out  1  one-cycle pulse when a new result has been latched.
INST_READOUT  out  1  snapshot strobe to the channel.
SPI_CLK  out  1  serial clock to the channel.
SELECT_REG  out  3  byte select to the channel, 0..6.
CNT_SER  in  1  serial data from the channel; asynchronous to FCLK.
CA, CB, CC, CD, CE  out  10 each  deserialized counter values.
TRIG_CNT  out  3  deserialized trigger count.
FRAME_ERR  out  1  present only with the optional feature.

Behaviour:
- Reset values: all outputs 0. FSM in IDLE. CNT_SER synchronizer flops cleared.
- Frame word W[55:0] = {3'b000, TRIG_CNT, CE, CD, CC, CB, CA}.
- The channel updates CNT_SER on each SPI_CLK rise. After rise k of byte i it presents W[55-8i-k], for k = 0..7. Its internal position counter wraps modulo 8 and is cleared only by RSTB.
- Consequence: SPI_CLK rises must always come in complete groups of 8.
- CNT_SER passes through a 2-flop synchronizer clocked by FCLK.
- Sampling rule: each bit is sampled from the synchronizer output on the last FCLK cycle of the SPI_CLK low phase that follows its rise.
- Capture: sampled bits shift MSB-first into a 56-bit shift register.
- FSM states and transitions:
  - IDLE: BUSY=0, SPI_CLK=0, SELECT_REG=0. START -> ARM.
  - ARM: INST_READOUT=1 for INST_PULSE_LEN cycles, then SETTLE.
  - SETTLE: wait SETTLE_CYCLES, then SHIFT_HI.
  - SHIFT_HI: SPI_CLK=1 for SCLK_DIV cycles, then SHIFT_LO.
  - SHIFT_LO: SPI_CLK=0 for SCLK_DIV cycles, then sample. If bit index = 55 -> LATCH, else increment bit index -> SHIFT_HI.
  - LATCH: load CA..CE and TRIG_CNT from the shift register, pulse DONE, -> IDLE.
- BUSY = 1 in every state except IDLE.
- Bit index is 6 bits. SELECT_REG = bitidx[5:3]. It changes only in SHIFT_LO, at least SCLK_DIV cycles before the next rise.
- Latency: DONE asserts exactly 1 + INST_PULSE_LEN + SETTLE_CYCLES + 112·SCLK_DIV cycles after the FCLK edge that samples START. With default parameters this is 459 cycles.
- Result outputs hold their values until the next LATCH. They are never partially updated.
- START while BUSY: ignored, not queued.
- ABORT in ARM or SETTLE:
  - go directly to IDLE; INST_READOUT drops the same cycle.
  - no DONE; result outputs unchanged.
- ABORT in SHIFT_HI or SHIFT_LO:
  - finish the current 8-rise group, then go to IDLE. No further captures are stored.
  - no DONE; result outputs unchanged.
  - ABORT during the final byte completes normally with DONE.
- ABORT and START in the same cycle while in IDLE: both ignored.
- RSTB asserted mid-operation: immediate return to reset values. The channel is reset by the same RSTB, so alignment is preserved.

Optional Feature:
- Macro: PSEC5_RDO_FRAME_CHECK_EN.
- When defined:
  - FRAME_ERR output exists, reset value 0.
  - At LATCH, FRAME_ERR = OR of captured W[55:53] (padding must be zero). It is updated only at LATCH and held until the next LATCH.
  - Result outputs and DONE behave identically regardless of FRAME_ERR.
- When undefined: no FRAME_ERR port and no check logic.

Test Plan:
1. Channel model loaded with CA=10'h3FF, CB=0, CC=10'h155, CD=10'h2AA, CE=10'h001, TRIG_CNT=3'b100, default parameters; pulse START -> INST_READOUT high 2 cycles, exactly 56 SPI_CLK rises, SELECT_REG stepping 0..6 every 8 rises, DONE at cycle 459, outputs equal the model values.
2. START pulsed again at cycle 100 of a readout -> ignored; exactly one DONE, 56 rises total.
3. ABORT asserted after the 19th rise -> 24 rises total, BUSY low, no DONE, outputs still hold the prior result; a following full readout returns correct values, proving alignment.
4. ABORT during SETTLE -> zero SPI_CLK rises, return to IDLE next cycle, no DONE.
5. RSTB low at rise 30 -> all outputs 0 asynchronously; after release, a full readout returns correct values.
6. With PSEC5_RDO_FRAME_CHECK_EN defined, channel model drives W[54]=1 -> FRAME_ERR=1 at DONE; a clean frame afterwards -> FRAME_ERR=0.
